// File: rtl/vector_ram_bank_arbiter.sv
// Generic single-clock FIFO with show-ahead head output.
// Latency: a pushed entry is visible at the head on the cycle after the push.
// Backpressure: push is ignored when full, pop is ignored when empty.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             empty,
    output logic             full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign head_dat = mem[rd_ptr];

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
        return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
    endfunction

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Read/write pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// Round-robin arbiter sharing one RAM bank among PORTS requesters, with tagged read responses.
// Latency: grant and bank issue are combinational; read response appears RDELAY+1 cycles after grant.
// Backpressure: reads need a credit (one per response buffer slot); writes always go; flush blocks grants.
module vector_ram_bank_arbiter #(
    parameter int PORTS      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int RDELAY     = 1,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [PORTS-1:0]              req_valid,
    output logic [PORTS-1:0]              req_ready,
    input  logic [PORTS-1:0]              req_write,
    input  logic [PORTS*ADDR_WIDTH-1:0]   req_addr,
    input  logic [PORTS*DATA_WIDTH-1:0]   req_wdata,
    output logic                          bank_arvalid,
    output logic [ADDR_WIDTH-1:0]         bank_raddr,
    output logic                          bank_wvalid,
    output logic [ADDR_WIDTH-1:0]         bank_waddr,
    output logic [DATA_WIDTH-1:0]         bank_wdata,
    input  logic                          bank_rvalid,
    input  logic [DATA_WIDTH-1:0]         bank_rdata,
    output logic                          rsp_valid,
    output logic [$clog2(PORTS)-1:0]      rsp_port,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    input  logic                          rsp_ready,
    input  logic                          flush,
    output logic                          flush_done
);
    localparam int PW = $clog2(PORTS);
    localparam int CW = $clog2(RSP_DEPTH + 1);

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [PW-1:0]           rr_ptr;
    logic [CW-1:0]           credits;
    logic [PORTS-1:0]        eligible;
    logic                    gnt_vld;
    logic [PW-1:0]           gnt_idx;
    logic                    gnt_write;
    logic                    rd_issue;
    logic                    wr_issue;
    logic [RDELAY-1:0]       tag_vld;
    logic [RDELAY-1:0][PW-1:0] tag_port;
    logic                    rsp_push;
    logic                    rsp_pop;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic [PW+DATA_WIDTH-1:0] fifo_head;

    // Round-robin search from rr_ptr; a read needs a free credit, a write never waits.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = rr_ptr;
        for (int i = 0; i < PORTS; i++) begin
            eligible[i] = req_valid[i] && (req_write[i] || (credits != '0));
        end
        if (rst_n && (state == RUN)) begin
            for (int k = 0; k < PORTS; k++) begin
                if (!gnt_vld && eligible[rr_ptr + PW'(k)]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = rr_ptr + PW'(k);
                end
            end
        end
    end

    assign req_ready    = gnt_vld ? (PORTS'(1) << gnt_idx) : '0;
    assign gnt_write    = req_write[gnt_idx];
    assign rd_issue     = gnt_vld && !gnt_write;
    assign wr_issue     = gnt_vld && gnt_write;
    assign bank_arvalid = rd_issue;
    assign bank_wvalid  = wr_issue;
    assign bank_raddr   = req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign bank_waddr   = req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign bank_wdata   = req_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];

    // Pointer moves past the winner; idle cycles leave it in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (gnt_vld) begin
            rr_ptr <= gnt_idx + PW'(1);
        end
    end

    // Tag valid bits track reads in the bank; cleared on reset so stale returns are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld <= '0;
        end else begin
            tag_vld[0] <= rd_issue;
            for (int s = 1; s < RDELAY; s++) begin
                tag_vld[s] <= tag_vld[s-1];
            end
        end
    end

    // Port ids travel alongside the valid bits; qualified by tag_vld, so no reset.
    always_ff @(posedge clk) begin
        tag_port[0] <= gnt_idx;
        for (int s = 1; s < RDELAY; s++) begin
            tag_port[s] <= tag_port[s-1];
        end
    end

    assign rsp_push = bank_rvalid && tag_vld[RDELAY-1];
    assign rsp_pop  = rsp_valid && rsp_ready;

    fifo #(
        .WIDTH (PW + DATA_WIDTH),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (rsp_push),
        .push_dat ({tag_port[RDELAY-1], bank_rdata}),
        .pop      (rsp_pop),
        .head_dat (fifo_head),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    assign rsp_valid = !fifo_empty;
    assign rsp_port  = fifo_head[PW+DATA_WIDTH-1:DATA_WIDTH];
    assign rsp_data  = fifo_head[DATA_WIDTH-1:0];

    // Credits = free response slots not yet claimed by an issued read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits <= CW'(RSP_DEPTH);
        end else begin
            case ({rd_issue, rsp_pop})
                2'b10:   credits <= credits - CW'(1);
                2'b01:   credits <= credits + CW'(1);
                default: credits <= credits;
            endcase
        end
    end

    // State register for the run/drain controller.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Drain ends once every credit is back, i.e. nothing in the bank or the buffer.
    always_comb begin
        state_nxt  = state;
        flush_done = 1'b0;
        case (state)
            RUN: begin
                if (flush) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (credits == CW'(RSP_DEPTH)) begin
                    state_nxt  = RUN;
                    flush_done = 1'b1;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // Every tagged return has a reserved slot, so the buffer can never overflow.
    assert property (@(posedge clk) disable iff (!rst_n) !(rsp_push && fifo_full));
    assert property (@(posedge clk) disable iff (!rst_n) credits <= CW'(RSP_DEPTH));
endmodule

// File: tb/tb_vector_ram_bank_arbiter.sv
// Randomized bench for vector_ram_bank_arbiter against a transaction-level reference model.
// Inputs change at the falling edge; outputs are compared 1 ns later, mid low phase.
// The bank is emulated in the bench: a memory array plus an RDELAY-deep return delay line.
module tb_vector_ram_bank_arbiter;
    localparam int P    = 4;
    localparam int DW   = 32;
    localparam int AW   = 10;
    localparam int RD   = 1;
    localparam int RSPD = 4;
    localparam int PW   = $clog2(P);

    logic            clk = 1'b0;
    logic            rst_n;
    logic [P-1:0]    req_valid;
    logic [P-1:0]    req_ready;
    logic [P-1:0]    req_write;
    logic [P*AW-1:0] req_addr;
    logic [P*DW-1:0] req_wdata;
    logic            bank_arvalid;
    logic [AW-1:0]   bank_raddr;
    logic            bank_wvalid;
    logic [AW-1:0]   bank_waddr;
    logic [DW-1:0]   bank_wdata;
    logic            bank_rvalid;
    logic [DW-1:0]   bank_rdata;
    logic            rsp_valid;
    logic [PW-1:0]   rsp_port;
    logic [DW-1:0]   rsp_data;
    logic            rsp_ready;
    logic            flush;
    logic            flush_done;

    always #5 clk = ~clk;

    vector_ram_bank_arbiter #(
        .PORTS      (P),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .RDELAY     (RD),
        .RSP_DEPTH  (RSPD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .bank_arvalid (bank_arvalid),
        .bank_raddr   (bank_raddr),
        .bank_wvalid  (bank_wvalid),
        .bank_waddr   (bank_waddr),
        .bank_wdata   (bank_wdata),
        .bank_rvalid  (bank_rvalid),
        .bank_rdata   (bank_rdata),
        .rsp_valid    (rsp_valid),
        .rsp_port     (rsp_port),
        .rsp_data     (rsp_data),
        .rsp_ready    (rsp_ready),
        .flush        (flush),
        .flush_done   (flush_done)
    );

    typedef struct {
        int            port;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] bmem [1024];
    logic          bk_vld [RD];
    logic [DW-1:0] bk_dat [RD];
    logic          stale;
    int            total;
    int            bad;
    int            cyc;
    int            m_ptr;
    int            m_out;
    bit            m_run;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 1'b1;
        m_ptr = 0;
        m_out = 0;
        exp_q.delete();
    endtask

    // One clock cycle: drive, compare against the model, advance bank and model.
    task automatic run_cycle(input logic [P-1:0] v, input logic [P-1:0] w,
                             input logic rr, input logic fl, input int fa);
        int            g;
        logic [AW-1:0] a [P];
        logic [DW-1:0] d [P];
        logic [P-1:0]  exp_rdy;
        logic          exp_rd;
        logic          exp_wr;
        logic          exp_rv;
        logic          exp_fd;
        exp_t          e;

        for (int i = 0; i < P; i++) begin
            a[i] = (fa >= 0) ? AW'(fa) : AW'($urandom_range(0, 15));
            d[i] = (fa >= 0) ? 32'h0000_00A5 : $urandom;
            req_addr[i*AW +: AW]  = a[i];
            req_wdata[i*DW +: DW] = d[i];
        end
        req_valid   = v;
        req_write   = w;
        rsp_ready   = rr;
        flush       = fl;
        bank_rvalid = bk_vld[RD-1] | stale;
        bank_rdata  = stale ? 32'hDEAD_BEEF : bk_dat[RD-1];
        stale       = 1'b0;
        #1;

        g = -1;
        if (rst_n && m_run) begin
            for (int k = 0; k < P; k++) begin
                int pp;
                pp = (m_ptr + k) % P;
                if (g < 0 && v[pp] && (w[pp] || m_out < RSPD)) g = pp;
            end
        end
        exp_rdy = '0;
        exp_rd  = 1'b0;
        exp_wr  = 1'b0;
        if (g >= 0) begin
            exp_rdy[g] = 1'b1;
            exp_rd     = !w[g];
            exp_wr     = w[g];
        end
        check("req_ready", req_ready, exp_rdy);
        check("bank_arvalid", bank_arvalid, exp_rd);
        check("bank_wvalid", bank_wvalid, exp_wr);
        if (exp_rd) check("bank_raddr", bank_raddr, a[g]);
        if (exp_wr) begin
            check("bank_waddr", bank_waddr, a[g]);
            check("bank_wdata", bank_wdata, d[g]);
        end
        exp_rv = rst_n && (exp_q.size() > 0) && (exp_q[0].due <= cyc);
        check("rsp_valid", rsp_valid, exp_rv);
        if (exp_rv) begin
            check("rsp_port", rsp_port, exp_q[0].port);
            check("rsp_data", rsp_data, exp_q[0].data);
        end
        exp_fd = rst_n && !m_run && (m_out == 0);
        check("flush_done", flush_done, exp_fd);

        if (rst_n) begin
            if (exp_rv && rr) begin
                void'(exp_q.pop_front());
                m_out--;
            end
            if (g >= 0) begin
                m_ptr = (g + 1) % P;
                if (!w[g]) begin
                    e.port = g;
                    e.data = bmem[a[g]];
                    e.due  = cyc + RD + 1;
                    exp_q.push_back(e);
                    m_out++;
                end
            end
            if (m_run && fl) m_run = 1'b0;
            else if (exp_fd) m_run = 1'b1;
        end

        for (int s = RD - 1; s > 0; s--) begin
            bk_vld[s] = bk_vld[s-1];
            bk_dat[s] = bk_dat[s-1];
        end
        bk_vld[0] = bank_arvalid;
        bk_dat[0] = bmem[bank_raddr];
        if (bank_wvalid) bmem[bank_waddr] = bank_wdata;

        cyc++;
        @(negedge clk);
    endtask

    // Hold reset for n cycles under random traffic; the first cycle after release injects a stray return.
    task automatic do_reset(input int n);
        rst_n = 1'b0;
        model_reset();
        repeat (n) run_cycle(P'($urandom), P'($urandom), 1'b1, 1'b0, -1);
        rst_n = 1'b1;
        stale = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        req_valid   = '0;
        req_write   = '0;
        req_addr    = '0;
        req_wdata   = '0;
        rsp_ready   = 1'b0;
        flush       = 1'b0;
        bank_rvalid = 1'b0;
        bank_rdata  = '0;
        stale       = 1'b0;
        total       = 0;
        bad         = 0;
        cyc         = 0;
        for (int i = 0; i < 1024; i++) bmem[i] = '0;
        for (int s = 0; s < RD; s++) begin
            bk_vld[s] = 1'b0;
            bk_dat[s] = '0;
        end
        model_reset();
        @(negedge clk);
        do_reset(3);

        // All ports reading, responses drained every cycle.
        repeat (12) run_cycle('1, '0, 1'b1, 1'b0, -1);
        repeat (6)  run_cycle('0, '0, 1'b1, 1'b0, -1);

        // Single port exhausting credits, then released.
        repeat (8)  run_cycle(4'b0100, '0, 1'b0, 1'b0, -1);
        repeat (3)  run_cycle(4'b0100, '0, 1'b1, 1'b0, -1);
        repeat (8)  run_cycle('0, '0, 1'b1, 1'b0, -1);

        // Write while out of credits.
        repeat (6)  run_cycle(4'b0100, '0, 1'b0, 1'b0, -1);
        repeat (2)  run_cycle(4'b0010, 4'b0010, 1'b0, 1'b0, -1);
        repeat (8)  run_cycle('0, '0, 1'b1, 1'b0, -1);

        // Write then read back the same word from another port.
        run_cycle(4'b0001, 4'b0001, 1'b1, 1'b0, 5);
        run_cycle(4'b1000, 4'b0000, 1'b1, 1'b0, 5);
        repeat (4)  run_cycle('0, '0, 1'b1, 1'b0, -1);

        // Flush with three reads outstanding.
        repeat (3)  run_cycle(4'b0111, '0, 1'b0, 1'b0, -1);
        run_cycle('0, '0, 1'b0, 1'b1, -1);
        repeat (4)  run_cycle('1, '0, 1'b0, 1'b0, -1);
        repeat (8)  run_cycle('1, '0, 1'b1, 1'b0, -1);
        repeat (6)  run_cycle('0, '0, 1'b1, 1'b0, -1);

        // Random mix with occasional flushes and mid-traffic resets.
        for (int n = 0; n < 3000; n++) begin
            if (n % 750 == 749) do_reset(2);
            else run_cycle(P'($urandom), P'($urandom) & P'($urandom),
                           ($urandom_range(0, 9) < 7), ($urandom_range(0, 49) == 0), -1);
        end

        // Reset with two reads in flight, then confirm the full credit count is back.
        repeat (6)  run_cycle('0, '0, 1'b1, 1'b0, -1);
        repeat (2)  run_cycle(4'b0100, '0, 1'b0, 1'b0, -1);
        do_reset(2);
        repeat (6)  run_cycle(4'b0100, '0, 1'b0, 1'b0, -1);
        repeat (8)  run_cycle('0, '0, 1'b1, 1'b0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
